ex_core_decode: RTL

- Decode/issue stage directly upstream of ex_core_alu.
- Accepts RV32I register-register (OP) and register-immediate (OP-IMM) instructions over a valid/ready handshake.
- Reads a 32x32 register file and produces operand1/operand2/op/rd in a registered output slot that feeds the ALU.
- Tracks in-flight destinations with a scoreboard; writeback arrives on a separate write port.

---
 rtl/ex_core_pkg.sv | 77 +++++++
 rtl/ex_core_decode_if.sv | 31 +++
 rtl/ex_core_rf.sv | 34 +++
 rtl/ex_core_decode.sv | 95 +++++++++
 4 files changed

// File: rtl/ex_core_pkg.sv
// Shared ALU opcode encoding and RV32I OP/OP-IMM field decoding for the
// ex_core decode/ALU pair.
package ex_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic    legal;
    logic    is_r;
    logic    is_shift_imm;
    alu_op_t op;
  } dec_t;

  function automatic alu_op_t base_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode_fields(input logic [6:0] opc,
                                         input logic [2:0] f3,
                                         input logic [6:0] f7);
    dec_t d;
    d.legal        = 1'b0;
    d.is_r         = 1'b0;
    d.is_shift_imm = 1'b0;
    d.op           = base_op(f3);
    if (opc == OPC_OP) begin
      d.is_r = 1'b1;
      if (f7 == 7'b0000000) begin
        d.legal = 1'b1;
      end else if (f7 == F7_ALT && f3 == 3'b000) begin
        d.legal = 1'b1;
        d.op    = ALU_SUB;
      end else if (f7 == F7_ALT && f3 == 3'b101) begin
        d.legal = 1'b1;
        d.op    = ALU_SRA;
      end
    end else if (opc == OPC_OP_IMM) begin
      d.legal = 1'b1;
      if (f3 == 3'b001) begin
        d.is_shift_imm = 1'b1;
        d.legal        = (f7 == 7'b0000000);
      end else if (f3 == 3'b101) begin
        d.is_shift_imm = 1'b1;
        if (f7 == F7_ALT) d.op = ALU_SRA;
        else              d.legal = (f7 == 7'b0000000);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ex_core_decode_if.sv
// Issue handshake, ALU-facing output slot and register writeback port of
// the decode stage.
interface ex_core_decode_if
  import ex_core_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_operand1;
  logic [XLEN-1:0] out_operand2;
  alu_op_t         out_op;
  logic [4:0]      out_rd;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_operand1, out_operand2, out_op, out_rd, illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_operand1, out_operand2, out_op, out_rd, illegal
  );
endinterface

// File: rtl/ex_core_rf.sv
// Register file with two combinational read ports, one write port,
// write-through bypass and x0 hardwired to zero.
module ex_core_rf #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);
  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // A write landing this cycle is visible to a read of the same index.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != 5'd0) o_rd1 = (i_we && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
    if (i_ra2 != 5'd0) o_rd2 = (i_we && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
  end
endmodule

// File: rtl/ex_core_decode.sv
// Decode/issue stage for RV32I OP and OP-IMM: scoreboarded operand read
// into a single registered slot that feeds ex_core_alu.
module ex_core_decode
  import ex_core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input logic             clk,
  input logic             rst,
  ex_core_decode_if.slave bus
);
  logic [4:0]          w_rs1, w_rs2, w_rd;
  dec_t                w_dec;
  logic [XLEN-1:0]     w_rd1, w_rd2, w_opnd2;
  logic [NUM_REGS-1:0] r_pend, w_pend_eff, w_set, w_clr;
  logic                w_hazard, w_accept, w_load;
  logic                r_valid, r_illegal;
  logic [XLEN-1:0]     r_op1, r_op2;
  alu_op_t             r_op;
  logic [4:0]          r_rd;

  assign w_rs1 = bus.in_instr[19:15];
  assign w_rs2 = bus.in_instr[24:20];
  assign w_rd  = bus.in_instr[11:7];
  assign w_dec = decode_fields(bus.in_instr[6:0], bus.in_instr[14:12], bus.in_instr[31:25]);

  ex_core_rf #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .i_we  (bus.wb_en),
    .i_wa  (bus.wb_rd),
    .i_wd  (bus.wb_data),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // A writeback this cycle already resolves its dependency, so it must not stall.
  always_comb begin
    w_pend_eff = r_pend;
    w_clr      = '0;
    w_set      = '0;
    if (bus.wb_en) begin
      w_pend_eff[bus.wb_rd] = 1'b0;
      w_clr[bus.wb_rd]      = 1'b1;
    end
    if (w_load && w_rd != 5'd0) w_set[w_rd] = 1'b1;
  end

  assign w_hazard = w_dec.legal &&
                    (w_pend_eff[w_rs1] || (w_dec.is_r && w_pend_eff[w_rs2]) || w_pend_eff[w_rd]);
  assign bus.in_ready = !w_hazard && (!r_valid || bus.out_ready);
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_load   = w_accept && w_dec.legal;

  always_comb begin
    if (w_dec.is_shift_imm) w_opnd2 = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
    else if (w_dec.is_r)    w_opnd2 = w_rd2;
    else                    w_opnd2 = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  end

  // Output slot: loads on a legal accept, otherwise drains on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_op      <= ALU_ADD;
      r_rd      <= '0;
      r_pend    <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_op1   <= w_rd1;
        r_op2   <= w_opnd2;
        r_op    <= w_dec.op;
        r_rd    <= w_rd;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
      r_illegal <= w_accept && !w_dec.legal;
      r_pend    <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign bus.out_valid    = r_valid;
  assign bus.out_operand1 = r_op1;
  assign bus.out_operand2 = r_op2;
  assign bus.out_op       = r_op;
  assign bus.out_rd       = r_rd;
  assign bus.illegal      = r_illegal;
endmodule
